// File: rtl/mux_serializer.sv
// N-channel, W-bit time-division serializer: accepts an N*W word, emits one channel per beat.
// Optional MUX_SERIALIZER_B2B_EN accepts the next word on the last beat for bubble-free streaming.
module mux_serializer #(
  parameter  int N  = 16,
  parameter  int W  = 1,
  localparam int SW = $clog2(N),
  localparam int LW = $clog2(N + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_valid,
  output logic           i_ready,
  input  logic [N*W-1:0] i_data,
  input  logic [LW-1:0]  i_len,
  output logic           o_valid,
  input  logic           o_ready,
  output logic [W-1:0]   o_data,
  output logic [SW-1:0]  o_index,
  output logic           o_last
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]     state;
  logic [N*W-1:0] word;
  logic [LW-1:0]  len;
  logic [SW-1:0]  index;
  logic [W-1:0]   chan [N];
  logic           shifting;
  logic           out_fire;
  logic           in_fire;
  logic [LW-1:0]  len_eff;

  for (genvar k = 0; k < N; k++) begin : g_chan
    assign chan[k] = word[k*W +: W];
  end

  assign shifting = (state == SHIFT);
  assign o_valid  = shifting;
  assign o_index  = index;
  assign o_last   = shifting && (LW'(index) == len - LW'(1));
  assign o_data   = shifting ? chan[index] : '0;

  // A zero or oversized length request means "all channels".
  assign len_eff  = ((i_len == '0) || (i_len > LW'(N))) ? LW'(N) : i_len;

`ifdef MUX_SERIALIZER_B2B_EN
  assign i_ready  = rst && (!shifting || (o_ready && o_last));
`else
  assign i_ready  = rst && !shifting;
`endif

  assign out_fire = o_valid && o_ready;
  assign in_fire  = i_valid && i_ready;

  // A new word only arrives in IDLE or together with the last beat, so it takes priority.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      word  <= '0;
      len   <= '0;
      index <= '0;
    end else if (in_fire) begin
      state <= SHIFT;
      word  <= i_data;
      len   <= len_eff;
      index <= '0;
    end else if (out_fire) begin
      if (o_last) begin
        state <= IDLE;
        index <= '0;
      end else begin
        index <= index + SW'(1);
      end
    end
  end

endmodule

// File: tb/tb_mux_serializer.sv
// Randomized bench for mux_serializer; a queue of expected beats is built from each accepted word.
// Honors MUX_SERIALIZER_B2B_EN when it is defined for the build.
module tb_mux_serializer;

  localparam int N  = 16;
  localparam int W  = 8;
  localparam int SW = $clog2(N);
  localparam int LW = $clog2(N + 1);

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           i_valid = 1'b0;
  logic           i_ready;
  logic [N*W-1:0] i_data = '0;
  logic [LW-1:0]  i_len = '0;
  logic           o_valid;
  logic           o_ready = 1'b0;
  logic [W-1:0]   o_data;
  logic [SW-1:0]  o_index;
  logic           o_last;

  typedef struct {
    logic [W-1:0] data;
    int           idx;
    bit           last;
  } beat_t;

  beat_t exp_q[$];
  int    pass_count = 0;
  int    total_count = 0;
  bit    prev_rst_low = 1'b1;

  always #5 clk = ~clk;

  mux_serializer #(.N(N), .W(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .i_valid (i_valid),
    .i_ready (i_ready),
    .i_data  (i_data),
    .i_len   (i_len),
    .o_valid (o_valid),
    .o_ready (o_ready),
    .o_data  (o_data),
    .o_index (o_index),
    .o_last  (o_last)
  );

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total_count++;
    if (got === exp) pass_count++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [N*W-1:0] rand_word();
    logic [N*W-1:0] w;
    for (int k = 0; k < N; k++) w[k*W +: W] = W'($urandom);
    return w;
  endfunction

  // One clock cycle: check outputs against the model, drive inputs, then advance the model.
  task automatic applyStimulus(input logic r, input logic iv, input logic [N*W-1:0] d,
                               input logic [LW-1:0] l, input logic ordy);
    bit    exp_valid, exp_ready, out_fire, in_fire;
    int    len_eff;
    beat_t b;
    exp_valid = (exp_q.size() != 0);
    checkOutput("o_valid", o_valid, exp_valid);
    if (exp_valid) begin
      checkOutput("o_data", o_data, exp_q[0].data);
      checkOutput("o_index", o_index, exp_q[0].idx);
      checkOutput("o_last", o_last, exp_q[0].last);
    end else begin
      checkOutput("o_index_idle", o_index, 0);
      checkOutput("o_last_idle", o_last, 0);
      if (prev_rst_low) checkOutput("o_data_reset", o_data, 0);
    end
    rst = r; i_valid = iv; i_data = d; i_len = l; o_ready = ordy;
    #1;
`ifdef MUX_SERIALIZER_B2B_EN
    exp_ready = r && (!exp_valid || (ordy && exp_q[0].last));
`else
    exp_ready = r && !exp_valid;
`endif
    checkOutput("i_ready", i_ready, exp_ready);
    out_fire = exp_valid && ordy;
    in_fire  = iv && exp_ready;
    @(posedge clk);
    if (!r) begin
      exp_q.delete();
    end else begin
      if (out_fire) void'(exp_q.pop_front());
      if (in_fire) begin
        len_eff = (int'(l) == 0 || int'(l) > N) ? N : int'(l);
        for (int k = 0; k < len_eff; k++) begin
          b.data = d[k*W +: W];
          b.idx  = k;
          b.last = (k == len_eff - 1);
          exp_q.push_back(b);
        end
      end
    end
    prev_rst_low = !r;
    @(negedge clk);
  endtask

  task automatic drain(input int cycles);
    for (int i = 0; i < cycles; i++) applyStimulus(1'b1, 1'b0, rand_word(), '0, 1'b1);
  endtask

  initial begin
    logic [N*W-1:0] d;
    logic           pat [4];
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;

    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    $display("[TB] reset held with traffic offered");
    repeat (3) applyStimulus(1'b0, 1'b1, rand_word(), '0, 1'b1);
    applyStimulus(1'b1, 1'b0, '0, '0, 1'b1);

    $display("[TB] full word, length 0 means N");
    for (int k = 0; k < N; k++) d[k*W +: W] = W'(k) ^ 8'h5A;
    applyStimulus(1'b1, 1'b1, d, '0, 1'b1);
    drain(N + 2);

    $display("[TB] backpressure with input churn");
    d = rand_word();
    d[31:0] = 32'h44332211;
    applyStimulus(1'b1, 1'b1, d, LW'(4), 1'b1);
    for (int i = 0; i < 12; i++)
      applyStimulus(1'b1, 1'($urandom), rand_word(), LW'($urandom), pat[i % 4]);
    drain(2 * N + 4);

    $display("[TB] short and oversized lengths");
    applyStimulus(1'b1, 1'b1, rand_word(), LW'(1), 1'b1);
    drain(2);
    applyStimulus(1'b1, 1'b1, rand_word(), LW'(N + 1), 1'b1);
    drain(N + 2);

    $display("[TB] reset in the middle of a word");
    applyStimulus(1'b1, 1'b1, rand_word(), '0, 1'b1);
    drain(5);
    applyStimulus(1'b0, 1'b0, rand_word(), '0, 1'b1);
    applyStimulus(1'b1, 1'b1, rand_word(), '0, 1'b1);
    drain(N + 2);

    $display("[TB] consecutive words with valid held high");
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 1'b1, rand_word(), LW'(3), 1'b1);
    drain(N + 2);

    $display("[TB] random traffic");
    for (int i = 0; i < 500; i++)
      applyStimulus(1'(($urandom % 40) != 0), 1'($urandom), rand_word(),
                    LW'($urandom), 1'(($urandom % 4) != 0));
    drain(2 * N + 4);

    $display("%0d/%0d checks passed", pass_count, total_count);
    $finish;
  end

endmodule
